vertex_accum_buffer_pp: RTL and testbench
=========================================

// Module: vertex_accum_buffer_pp
// PURPOSE
//  Parametrised, double-buffered (ping-pong) successor to the single-bank vertex accumulation buffer.
//  Accumulates a streamed feature vector (FV) from the Vertex PE per node, then drains it to the
//  Output Buffer via req/grant in LANES-wide beats. Drain of one bank overlaps fill of the other.
// PARAMETERS
//  FV_NUM     16  max FV elements per node (>=2)
//  FV_W        8  bits per FV element (unsigned)
//  LANES       2  elements per output beat (power of 2, <= FV_NUM)
//  NODE_ID_W  10  node id width
//  SATURATE    0  0: accumulate mod 2^FV_W; 1: clamp at 2^FV_W-1
// PORTS
//  clk          in   1              clock
//  reset        in   1              synchronous, active-high reset
//  in_valid     in   1              input beat valid
//  in_sos       in   1              first beat of a node's stream (qualified by in_valid)
//  in_eos       in   1              last beat of stream (may coincide with in_sos)
//  in_change    in   1              advance element index after this beat
//  in_data      in   FV_W           partial sum added to current element
//  in_node_id   in   NODE_ID_W      node id, captured on sos beat
//  bank_busy    out  1              no free bank; upstream must not start a stream
//  drop_err     out  1              1-cycle pulse: sos beat dropped while busy
//  out_req      out  1              request to Output Buffer
//  req_grant    in   1              grant from Output Buffer arbiter
//  out_valid    out  1              output beat valid
//  out_sos      out  1              first output beat
//  out_eos      out  1              last output beat
//  out_data     out  LANES*FV_W     lane i = element (beat*LANES+i), lane 0 in LSBs
//  out_node_id  out  NODE_ID_W      node id of draining bank
// BEHAVIOUR
//  Reset: both banks zeroed and EMPTY, wr_sel=rd_sel=0, fill FSM IDLE, drain FSM D_IDLE;
//   all outputs 0. Reset mid-stream or mid-drain discards all data; no partial beats afterwards.
//  Fill FSM {IDLE, FILL} on bank wr_sel, element index idx ($clog2(FV_NUM) bits):
//   IDLE: in_valid&in_sos & !bank_busy -> buf[0]+=in_data, capture node id, idx=in_change;
//    if in_eos also: count=1, bank FULL, wr_sel toggles, stay IDLE; else -> FILL.
//   IDLE: in_valid & in_sos & bank_busy -> beat dropped, drop_err=1 next cycle, state unchanged.
//   IDLE: in_valid without in_sos -> ignored.
//   FILL: each in_valid beat: buf[idx]+=in_data; in_change -> idx+1 (held at FV_NUM-1, no wrap).
//    in_sos inside FILL is treated as a normal beat (no restart).
//    in_eos -> count=idx+1 (idx before any change), bank FULL, wr_sel toggles, idx=0, -> IDLE.
//   in_valid=0 beats: no update in either state.
//  Add: FV_W-bit unsigned; SATURATE=0 wraps, SATURATE=1 clamps at all-ones.
//  bank_busy = bank[wr_sel] FULL (combinational from registered state); 0 while FILL.
//  Drain FSM {D_IDLE, D_WAIT, D_STREAM} on bank rd_sel:
//   D_IDLE: bank[rd_sel] FULL -> D_WAIT. Earliest out_req is the cycle after the eos beat.
//   D_WAIT: out_req=1, held until req_grant=1 sampled -> D_STREAM, beat=0. req_grant ignored elsewhere.
//   D_STREAM: out_req=0, out_valid=1 every cycle, nbeats=ceil(count/LANES); out_sos on beat 0,
//    out_eos on beat nbeats-1 (both on a 1-beat drain). Lanes with index >= count drive 0.
//    After last beat: bank[rd_sel] zeroed and EMPTY, rd_sel toggles, -> D_IDLE (1 idle cycle).
//  out_node_id valid whenever out_req or out_valid; otherwise 0.
//  Simultaneous: eos into bank A in same cycle bank B finishes draining -> both banks settle
//   consistently; bank_busy=0 next cycle. Both banks FULL -> drained in fill order.
// TESTING
//  1 FV_NUM=16,LANES=2: sos|eos single beat data=5,id=3 -> req next cycle; grant -> 1 beat
//    sos=eos=1, data={0,5}, id=3; bank returns EMPTY.
//  2 5-element stream, change every beat, data 1..5, grant at once -> 3 beats {2,1},{4,3},{0,5}, eos on 3rd.
//  3 Accumulate 3 beats 200,50,10 on elem 0: SATURATE=0 -> 4; SATURATE=1 -> 255.
//  4 Grant withheld: fill node A, fill node B -> bank_busy=1; sos for C dropped, drop_err
//    pulses; grant -> A drains then B drains, busy clears after A drained.
//  5 change beyond FV_NUM-1: 20 changing beats -> count=16, elem 15 holds sum of beats 16..20.
//  6 reset asserted mid-D_STREAM and mid-FILL -> all outputs 0 next cycle, no further beats,
//    new stream after reset drains correctly from bank 0.

Source files
------------

// File: rtl/vertex_accum_buffer_pp.sv
// vertex_accum_buffer_pp
// Ping-pong feature-vector accumulator between the Vertex PE and the Output Buffer.
// One bank fills from the PE stream while the other drains in LANES-wide beats.
//
// Fill FSM
//   state    | meaning
//   IDLE     | waiting for a start-of-stream beat on bank wr_sel
//   FILL     | accumulating beats into bank wr_sel at element idx
//
// Drain FSM
//   state    | meaning
//   D_IDLE   | bank rd_sel not yet full
//   D_WAIT   | requesting the Output Buffer, waiting for grant
//   D_STREAM | one output beat per cycle from bank rd_sel
module vertex_accum_buffer_pp #(
    parameter int FV_NUM    = 16,
    parameter int FV_W      = 8,
    parameter int LANES     = 2,
    parameter int NODE_ID_W = 10,
    parameter int SATURATE  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_sos,
    input  logic                   in_eos,
    input  logic                   in_change,
    input  logic [FV_W-1:0]        in_data,
    input  logic [NODE_ID_W-1:0]   in_node_id,
    output logic                   bank_busy,
    output logic                   drop_err,
    output logic                   out_req,
    input  logic                   req_grant,
    output logic                   out_valid,
    output logic                   out_sos,
    output logic                   out_eos,
    output logic [LANES*FV_W-1:0]  out_data,
    output logic [NODE_ID_W-1:0]   out_node_id
);

    localparam int IDX_W   = (FV_NUM > 1) ? $clog2(FV_NUM) : 1;
    localparam int CNT_W   = $clog2(FV_NUM + 1);
    localparam int LANE_SH = $clog2(LANES);
    localparam int EW      = CNT_W + LANE_SH + 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FV_NUM - 1);

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT,
        D_STREAM
    } drain_state_t;

    fill_state_t            r_fstate;
    fill_state_t            w_fstate_nxt;
    drain_state_t           r_dstate;
    drain_state_t           w_dstate_nxt;

    logic [FV_W-1:0]        r_buf  [2][FV_NUM];
    logic                   r_full [2];
    logic [CNT_W-1:0]       r_cnt  [2];
    logic [NODE_ID_W-1:0]   r_node [2];

    logic                   r_wr_sel;
    logic                   r_rd_sel;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_beat;
    logic                   r_drop;

    logic                   w_start;
    logic                   w_acc_en;
    logic [IDX_W-1:0]       w_acc_idx;
    logic                   w_commit;
    logic [CNT_W-1:0]       w_commit_cnt;
    logic                   w_drop;
    logic [FV_W-1:0]        w_old;
    logic [FV_W:0]          w_wide;
    logic [FV_W-1:0]        w_sum;

    logic [EW-1:0]          w_base;
    logic [EW-1:0]          w_nbeats;
    logic                   w_last;
    logic                   w_drain_done;

    // A full write bank blocks new streams; a bank being filled is never full.
    assign bank_busy = (r_fstate == IDLE) && r_full[r_wr_sel];
    assign drop_err  = r_drop;

    // Saturating or wrapping element add for the beat being accepted.
    assign w_old  = r_buf[r_wr_sel][w_acc_idx];
    assign w_wide = {1'b0, w_old} + {1'b0, in_data};
    assign w_sum  = ((SATURATE != 0) && w_wide[FV_W]) ? {FV_W{1'b1}} : w_wide[FV_W-1:0];

    // A single-beat stream always holds exactly one element.
    assign w_commit_cnt = (r_fstate == IDLE) ? CNT_W'(1) : (CNT_W'(r_idx) + CNT_W'(1));

    // Drain beat geometry for bank rd_sel.
    assign w_base   = EW'(r_beat) << LANE_SH;
    assign w_nbeats = (EW'(r_cnt[r_rd_sel]) + EW'(LANES - 1)) >> LANE_SH;
    assign w_last   = (EW'(r_beat) + EW'(1)) == w_nbeats;

    // State registers for both FSMs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fstate <= IDLE;
            r_dstate <= D_IDLE;
        end else begin
            r_fstate <= w_fstate_nxt;
            r_dstate <= w_dstate_nxt;
        end
    end

    // Fill next-state and accumulate/commit/drop decisions.
    always_comb begin
        w_fstate_nxt = r_fstate;
        w_start      = 1'b0;
        w_acc_en     = 1'b0;
        w_acc_idx    = '0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_fstate)
            IDLE: begin
                if (in_valid && in_sos) begin
                    if (bank_busy) begin
                        w_drop = 1'b1;
                    end else begin
                        w_start  = 1'b1;
                        w_acc_en = 1'b1;
                        if (in_eos) begin
                            w_commit = 1'b1;
                        end else begin
                            w_fstate_nxt = FILL;
                        end
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    w_acc_en  = 1'b1;
                    w_acc_idx = r_idx;
                    if (in_eos) begin
                        w_commit     = 1'b1;
                        w_fstate_nxt = IDLE;
                    end
                end
            end
            default: w_fstate_nxt = IDLE;
        endcase
    end

    // Drain next-state; a commit into the read bank starts the request one cycle early.
    always_comb begin
        w_dstate_nxt = r_dstate;
        w_drain_done = 1'b0;
        case (r_dstate)
            D_IDLE: begin
                if (r_full[r_rd_sel] || (w_commit && (r_wr_sel == r_rd_sel))) begin
                    w_dstate_nxt = D_WAIT;
                end
            end
            D_WAIT: begin
                if (req_grant) begin
                    w_dstate_nxt = D_STREAM;
                end
            end
            D_STREAM: begin
                if (w_last) begin
                    w_drain_done = 1'b1;
                    w_dstate_nxt = D_IDLE;
                end
            end
            default: w_dstate_nxt = D_IDLE;
        endcase
    end

    // Bank storage: drained bank is cleared, write bank accumulates and commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < FV_NUM; e++) begin
                    r_buf[b][e] <= '0;
                end
                r_full[b] <= 1'b0;
                r_cnt[b]  <= '0;
                r_node[b] <= '0;
            end
        end else begin
            if (w_drain_done) begin
                for (int e = 0; e < FV_NUM; e++) begin
                    r_buf[r_rd_sel][e] <= '0;
                end
                r_full[r_rd_sel] <= 1'b0;
                r_cnt[r_rd_sel]  <= '0;
            end
            if (w_start) begin
                r_node[r_wr_sel] <= in_node_id;
            end
            if (w_acc_en) begin
                r_buf[r_wr_sel][w_acc_idx] <= w_sum;
            end
            if (w_commit) begin
                r_full[r_wr_sel] <= 1'b1;
                r_cnt[r_wr_sel]  <= w_commit_cnt;
            end
        end
    end

    // Element index and write-bank select; index saturates at the last element.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= '0;
            r_wr_sel <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx <= IDX_W'(in_change && !in_eos);
            end else if (r_fstate == FILL && in_valid) begin
                if (in_eos) begin
                    r_idx <= '0;
                end else if (in_change && (r_idx != IDX_MAX)) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
            if (w_commit) begin
                r_wr_sel <= ~r_wr_sel;
            end
        end
    end

    // Beat counter and read-bank select.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat   <= '0;
            r_rd_sel <= 1'b0;
        end else begin
            if (r_dstate == D_WAIT) begin
                r_beat <= '0;
            end else if (r_dstate == D_STREAM) begin
                r_beat <= r_beat + CNT_W'(1);
            end
            if (w_drain_done) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    // One-cycle pulse for a start beat refused while both banks are occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop;
        end
    end

    // Output handshake and sideband, all decoded from registered state.
    always_comb begin
        out_req     = (r_dstate == D_WAIT);
        out_valid   = (r_dstate == D_STREAM);
        out_sos     = (r_dstate == D_STREAM) && (r_beat == '0);
        out_eos     = (r_dstate == D_STREAM) && w_last;
        out_node_id = '0;
        if ((r_dstate == D_WAIT) || (r_dstate == D_STREAM)) begin
            out_node_id = r_node[r_rd_sel];
        end
    end

    // Output lanes; elements past the stream's count read as zero.
    always_comb begin
        out_data = '0;
        if (r_dstate == D_STREAM) begin
            for (int l = 0; l < LANES; l++) begin
                if ((w_base + EW'(l)) < EW'(r_cnt[r_rd_sel])) begin
                    out_data[l*FV_W +: FV_W] = r_buf[r_rd_sel][IDX_W'(w_base + EW'(l))];
                end
            end
        end
    end

endmodule

// File: tb/tb_vertex_accum_buffer_pp.sv
// Bench for vertex_accum_buffer_pp (FV_NUM=16, FV_W=8, LANES=2).
// Expected output beats are queued when a stream's eos is driven and compared as beats appear.
module tb_vertex_accum_buffer_pp;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_sos, in_eos, in_change;
    logic [7:0]  in_data;
    logic [9:0]  in_node_id;
    logic        req_grant;

    logic        bank_busy, drop_err, out_req, out_valid, out_sos, out_eos;
    logic [15:0] out_data;
    logic [9:0]  out_node_id;

    logic        s_bank_busy, s_drop_err, s_out_req, s_out_valid, s_out_sos, s_out_eos;
    logic [15:0] s_out_data;
    logic [9:0]  s_out_node_id;

    int n_err;
    int n_chk;

    typedef struct {
        logic        sos;
        logic        eos;
        logic [15:0] data;
        logic [9:0]  id;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;

    logic [7:0]  m_vec[16];
    int          m_idx;
    bit          m_active;
    logic [9:0]  m_node;

    always #5 clk = ~clk;

    vertex_accum_buffer_pp #(
        .FV_NUM(16), .FV_W(8), .LANES(2), .NODE_ID_W(10), .SATURATE(0)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sos(in_sos), .in_eos(in_eos), .in_change(in_change),
        .in_data(in_data), .in_node_id(in_node_id),
        .bank_busy(bank_busy), .drop_err(drop_err), .out_req(out_req), .req_grant(req_grant),
        .out_valid(out_valid), .out_sos(out_sos), .out_eos(out_eos),
        .out_data(out_data), .out_node_id(out_node_id)
    );

    vertex_accum_buffer_pp #(
        .FV_NUM(16), .FV_W(8), .LANES(2), .NODE_ID_W(10), .SATURATE(1)
    ) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sos(in_sos), .in_eos(in_eos), .in_change(in_change),
        .in_data(in_data), .in_node_id(in_node_id),
        .bank_busy(s_bank_busy), .drop_err(s_drop_err), .out_req(s_out_req), .req_grant(req_grant),
        .out_valid(s_out_valid), .out_sos(s_out_sos), .out_eos(s_out_eos),
        .out_data(s_out_data), .out_node_id(s_out_node_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int cnt);
        exp_t e;
        int   nb;
        nb = (cnt + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            e.sos       = (b == 0);
            e.eos       = (b == nb - 1);
            e.id        = m_node;
            e.data[7:0]  = (2*b < cnt)     ? m_vec[2*b]     : 8'h00;
            e.data[15:8] = (2*b + 1 < cnt) ? m_vec[2*b + 1] : 8'h00;
            sb.push_back(e);
        end
    endtask

    // Drive one input cycle; track=0 marks a beat the DUT is expected to drop.
    task automatic feed(input logic v, input logic sos, input logic eos, input logic chg,
                        input logic [7:0] d, input logic [9:0] id, input bit track);
        @(negedge clk);
        in_valid   = v;
        in_sos     = sos;
        in_eos     = eos;
        in_change  = chg;
        in_data    = d;
        in_node_id = id;
        if (track && v) begin
            if (!m_active) begin
                if (sos) begin
                    for (int i = 0; i < 16; i++) m_vec[i] = 8'h00;
                    m_node   = id;
                    m_vec[0] = d;
                    m_idx    = chg ? 1 : 0;
                    if (eos) push_exp(1);
                    else     m_active = 1'b1;
                end
            end else begin
                m_vec[m_idx] = m_vec[m_idx] + d;
                if (eos) begin
                    push_exp(m_idx + 1);
                    m_active = 1'b0;
                end else if (chg && m_idx < 15) begin
                    m_idx++;
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        in_sos    = 1'b0;
        in_eos    = 1'b0;
        in_change = 1'b0;
        in_data   = 8'h00;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid || out_req) && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(sb.size() == 0 && !out_valid && !out_req), 32'd1);
    endtask

    // Scoreboard: every output beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_sos",  32'(out_sos),     32'(mon_e.sos));
                chk("beat_eos",  32'(out_eos),     32'(mon_e.eos));
                chk("beat_data", 32'(out_data),    32'(mon_e.data));
                chk("beat_id",   32'(out_node_id), 32'(mon_e.id));
                chk("beat_noreq", 32'(out_req),    32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_err = 0;
        n_chk = 0;
        m_active = 1'b0;
        m_idx = 0;
        m_node = '0;
        reset = 1'b1;
        in_valid = 1'b0; in_sos = 1'b0; in_eos = 1'b0; in_change = 1'b0;
        in_data = '0; in_node_id = '0;
        req_grant = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req",   32'(out_req),     32'd0);
        chk("rst_valid", 32'(out_valid),   32'd0);
        chk("rst_sos",   32'(out_sos),     32'd0);
        chk("rst_eos",   32'(out_eos),     32'd0);
        chk("rst_data",  32'(out_data),    32'd0);
        chk("rst_id",    32'(out_node_id), 32'd0);
        chk("rst_busy",  32'(bank_busy),   32'd0);
        chk("rst_drop",  32'(drop_err),    32'd0);
        chk("rst_sat",   32'({s_out_req, s_bank_busy, s_drop_err}), 32'd0);

        // Single sos|eos beat; a preceding non-sos beat must be ignored.
        feed(1, 0, 0, 0, 8'd99, 10'd0, 1);
        feed(1, 1, 1, 0, 8'd5, 10'd3, 1);
        #1 chk("t1_noreq", 32'(out_req), 32'd0);
        idle();
        #1;
        chk("t1_req",    32'(out_req),     32'd1);
        chk("t1_req_id", 32'(out_node_id), 32'd3);
        wait_done("t1_done", 20);
        chk("t1_empty", 32'(bank_busy), 32'd0);

        // Five elements with a bubble; three beats, last lane zero.
        feed(1, 1, 0, 1, 8'd1, 10'd4, 1);
        feed(1, 0, 0, 1, 8'd2, 10'd4, 1);
        feed(0, 0, 0, 1, 8'd9, 10'd4, 1);
        feed(1, 0, 0, 1, 8'd3, 10'd4, 1);
        feed(1, 0, 0, 1, 8'd4, 10'd4, 1);
        feed(1, 0, 1, 1, 8'd5, 10'd4, 1);
        idle();
        wait_done("t2_done", 20);

        // 200+50+10 on element 0: wraps to 4, saturating copy clamps to 255.
        feed(1, 1, 0, 0, 8'd200, 10'd5, 1);
        feed(1, 0, 0, 0, 8'd50, 10'd5, 1);
        feed(1, 0, 1, 0, 8'd10, 10'd5, 1);
        idle();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) found = 1'b1;
        end
        chk("t3_seen",     32'(found),         32'd1);
        chk("t3_sat_vld",  32'(s_out_valid),   32'd1);
        chk("t3_sat_data", 32'(s_out_data),    32'h00FF);
        chk("t3_sat_sose", 32'({s_out_sos, s_out_eos}), 32'd3);
        chk("t3_sat_id",   32'(s_out_node_id), 32'd5);
        wait_done("t3_done", 20);

        // Grant withheld: two banks fill, third stream dropped, then fill-order drain.
        req_grant = 1'b0;
        feed(1, 1, 0, 1, 8'd11, 10'd10, 1);
        feed(1, 0, 0, 1, 8'd12, 10'd10, 1);
        feed(1, 0, 1, 0, 8'd13, 10'd10, 1);
        idle();
        #1;
        chk("t4_reqA",  32'(out_req),   32'd1);
        chk("t4_free",  32'(bank_busy), 32'd0);
        feed(1, 1, 0, 1, 8'd21, 10'd11, 1);
        feed(1, 0, 1, 0, 8'd22, 10'd11, 1);
        idle();
        #1;
        chk("t4_busy",   32'(bank_busy),   32'd1);
        chk("t4_req_id", 32'(out_node_id), 32'd10);
        feed(1, 1, 1, 0, 8'd77, 10'd12, 0);
        idle();
        #1 chk("t4_drop_hi", 32'(drop_err), 32'd1);
        idle();
        #1 chk("t4_drop_lo", 32'(drop_err), 32'd0);
        repeat (3) idle();
        #1;
        chk("t4_hold_vld", 32'(out_valid), 32'd0);
        chk("t4_hold_req", 32'(out_req),   32'd1);
        req_grant = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_eos) found = 1'b1;
        end
        chk("t4_A_last",    32'(found),       32'd1);
        chk("t4_A_last_id", 32'(out_node_id), 32'd10);
        chk("t4_busy_A",    32'(bank_busy),   32'd1);
        @(negedge clk);
        #1 chk("t4_busy_clr", 32'(bank_busy), 32'd0);
        wait_done("t4_done", 20);

        // Twenty changing beats with a stray sos mid-stream: index holds at 15.
        for (int k = 1; k <= 20; k++) begin
            feed(1, (k == 1 || k == 3), (k == 20), 1, 8'(k), 10'd7, 1);
        end
        idle();
        wait_done("t5_done", 40);

        // Reset while bank 0 drains and bank 1 fills.
        for (int k = 1; k <= 5; k++) begin
            feed(1, (k == 1), (k == 5), 1, 8'(k * 3), 10'd20, 1);
        end
        feed(1, 1, 0, 1, 8'd40, 10'd21, 1);
        feed(1, 0, 0, 1, 8'd41, 10'd21, 1);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0; in_sos = 1'b0; in_eos = 1'b0; in_change = 1'b0; in_data = '0;
        #1 chk("t6_streaming", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        sb.delete();
        m_active = 1'b0;
        chk("t6_rst_vld",  32'(out_valid),   32'd0);
        chk("t6_rst_req",  32'(out_req),     32'd0);
        chk("t6_rst_se",   32'({out_sos, out_eos}), 32'd0);
        chk("t6_rst_data", 32'(out_data),    32'd0);
        chk("t6_rst_id",   32'(out_node_id), 32'd0);
        chk("t6_rst_busy", 32'({bank_busy, drop_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1 chk("t6_quiet", 32'({out_valid, out_req}), 32'd0);
        end
        feed(1, 1, 1, 0, 8'd7, 10'd9, 1);
        idle();
        #1;
        chk("t6_req",    32'(out_req),     32'd1);
        chk("t6_req_id", 32'(out_node_id), 32'd9);
        wait_done("t6_done", 20);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
